// File: rtl/rx_pkt_buf_1024x256.sv
// rx_pkt_buf_1024x256: store-and-forward RX packet buffer exposing only committed, error-free packets
module rx_pkt_buf_1024x256 #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 1024,
    parameter int PTR   = 10
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             wren,
    input  logic             wr_sop,
    input  logic             wr_eop,
    input  logic             wr_err,
    input  logic [WIDTH-1:0] datain,
    output logic             wrfull,
    output logic [PTR:0]     wrusedw,
    output logic             wr_drop,
    output logic [15:0]      drop_cnt,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             rd_eop,
    output logic             rdvalid,
    output logic             rdempty,
    output logic [PTR:0]     rdusedw,
    output logic [PTR:0]     pkt_cnt
);
    localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DISCARD = 2'd2;
    localparam logic [PTR:0] FULL_LVL = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] ONE = (PTR+1)'(1);
    logic [WIDTH:0] mem [DEPTH];
    logic [WIDTH:0] rdata;
    logic [PTR:0]   wr_ptr, commit_ptr, rd_ptr, base, wr_ptr_nxt;
    logic [1:0]     state, state_nxt;
    logic           start, room, take, overflow, abort, commit, bad, drop, pop, pop_eop;
    // A new packet (including an abort restart) is always written from commit_ptr
    always_comb begin
        start      = wren && wr_sop && (state != DISCARD || wr_eop);
        base       = start ? commit_ptr : wr_ptr;
        room       = (base - rd_ptr) != FULL_LVL;
        take       = wren && (start || state == ACCUM) && room;
        overflow   = wren && !room && state != DISCARD && (start || state == ACCUM);
        abort      = start && state == ACCUM;
        commit     = take && wr_eop && !wr_err;
        bad        = take && wr_eop && wr_err;
        drop       = abort || overflow || bad;
        wr_ptr_nxt = (take && !bad) ? base + ONE : drop ? commit_ptr : wr_ptr;
        state_nxt  = !wren ? state :
                     state == DISCARD ? (wr_eop ? IDLE : DISCARD) :
                     (overflow || take) ? (wr_eop ? IDLE : overflow ? DISCARD : ACCUM) : state;
        wrusedw    = wr_ptr - rd_ptr;
        rdusedw    = commit_ptr - rd_ptr;
        wrfull     = wrusedw == FULL_LVL;
        rdempty    = rd_ptr == commit_ptr;
        pop        = rden && !rdempty;
        rdata      = mem[rd_ptr[PTR-1:0]];
        pop_eop    = pop && rdata[WIDTH];
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
            dataout    <= '0;
            rd_eop     <= 1'b0;
            rdvalid    <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            rdvalid <= pop;
            wr_drop <= drop;
            pkt_cnt <= pkt_cnt + {{PTR{1'b0}}, commit} - {{PTR{1'b0}}, pop_eop};
            if (commit) commit_ptr <= base + ONE;
            if (pop) begin
                rd_ptr  <= rd_ptr + ONE;
                dataout <= rdata[WIDTH-1:0];
                rd_eop  <= rdata[WIDTH];
            end
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (take) mem[base[PTR-1:0]] <= {wr_eop, datain};
    end
endmodule

// File: tb/tb_rx_pkt_buf_1024x256.sv
// tb_rx_pkt_buf_1024x256: randomized and directed bench against a queue-based packet model
module tb_rx_pkt_buf_1024x256;
    localparam int W = 256, D = 1024, P = 10;
    logic clk = 0, reset_ = 0, wren = 0, wr_sop = 0, wr_eop = 0, wr_err = 0, rden = 0;
    logic [W-1:0] datain = '0;
    logic wrfull, wr_drop, rd_eop, rdvalid, rdempty;
    logic [P:0] wrusedw, rdusedw, pkt_cnt;
    logic [15:0] drop_cnt;
    logic [W-1:0] dataout;
    int errors = 0, checks = 0;
    logic [W:0] qc[$], qp[$];
    bit in_pkt = 0, discarding = 0, m_valid = 0, m_drop = 0, m_eop = 0, can_pop;
    logic [W-1:0] m_data = '0;
    int m_dcnt = 0, pk;

    always #5 clk = ~clk;

    rx_pkt_buf_1024x256 dut (
        .clk(clk), .reset_(reset_), .wren(wren), .wr_sop(wr_sop), .wr_eop(wr_eop),
        .wr_err(wr_err), .datain(datain), .wrfull(wrfull), .wrusedw(wrusedw),
        .wr_drop(wr_drop), .drop_cnt(drop_cnt), .rden(rden), .dataout(dataout),
        .rd_eop(rd_eop), .rdvalid(rdvalid), .rdempty(rdempty), .rdusedw(rdusedw),
        .pkt_cnt(pkt_cnt)
    );

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: committed beats in qc, the packet being received in qp
    function automatic bit mwrite(bit s, bit e, bit er, logic [W-1:0] d);
        if (discarding) begin
            if (!e) return 0;
            discarding = 0;
            if (!s || qc.size() == D) return 0;
        end else if (!in_pkt && !s) return 0;
        mwrite = 0;
        if (s && in_pkt) begin
            qp.delete();
            in_pkt = 0;
            mwrite = 1;
        end
        if (qc.size() + qp.size() == D) begin
            qp.delete();
            in_pkt = 0;
            discarding = !e;
            return 1;
        end
        qp.push_back({e, d});
        in_pkt = !e;
        if (e) begin
            if (er) begin
                qp.delete();
                mwrite = 1;
            end else begin
                foreach (qp[i]) qc.push_back(qp[i]);
                qp.delete();
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!reset_) begin
            qc.delete();
            qp.delete();
            in_pkt = 0;
            discarding = 0;
            m_valid = 0;
            m_drop = 0;
            m_eop = 0;
            m_data = '0;
            m_dcnt = 0;
        end else begin
            can_pop = qc.size() != 0;
            m_drop = wren ? mwrite(wr_sop, wr_eop, wr_err, datain) : 1'b0;
            if (m_drop && m_dcnt < 65535) m_dcnt++;
            m_valid = rden && can_pop;
            if (m_valid) begin
                m_data = qc[0][W-1:0];
                m_eop = qc[0][W];
                void'(qc.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_) begin
            pk = 0;
            foreach (qc[i]) pk += int'(qc[i][W]);
            chk("rdvalid", rdvalid, m_valid);
            chk("dataout", dataout, m_data);
            chk("rd_eop", rd_eop, m_eop);
            chk("wr_drop", wr_drop, m_drop);
            chk("drop_cnt", drop_cnt, m_dcnt);
            chk("wrusedw", wrusedw, qc.size() + qp.size());
            chk("rdusedw", rdusedw, qc.size());
            chk("pkt_cnt", pkt_cnt, pk);
            chk("rdempty", rdempty, qc.size() == 0);
            chk("wrfull", wrfull, qc.size() + qp.size() == D);
        end
    end

    task automatic cyc(bit w, bit s, bit e, bit er, bit r);
        wren = w; wr_sop = s; wr_eop = e; wr_err = er; rden = r;
        for (int i = 0; i < 8; i++) datain[i*32 +: 32] = $urandom;
        @(posedge clk);
        #2;
        wren = 0; wr_sop = 0; wr_eop = 0; wr_err = 0; rden = 0;
    endtask

    task automatic pkt(int n, bit er, bit r);
        for (int i = 0; i < n; i++) cyc(1, i == 0, i == n - 1, er && i == n - 1, r);
    endtask

    task automatic rd(int n);
        repeat (n) cyc(0, 0, 0, 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdempty", rdempty, 1);
        chk("rst_wrfull", wrfull, 0);
        chk("rst_wrusedw", wrusedw, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_rdvalid", rdvalid, 0);
        chk("rst_dataout", dataout, 0);
        reset_ = 1;
        cyc(0, 0, 0, 0, 0);
        pkt(4, 0, 0);
        chk("good_rdempty", rdempty, 0);
        chk("good_pkt_cnt", pkt_cnt, 1);
        chk("good_rdusedw", rdusedw, 4);
        rd(4);
        chk("good_drained_pkt", pkt_cnt, 0);
        chk("good_drained_empty", rdempty, 1);
        rd(1);
        chk("empty_rd_valid", rdvalid, 0);
        pkt(3, 1, 0);
        chk("err_drop_pulse", wr_drop, 1);
        chk("err_drop_cnt", drop_cnt, 1);
        chk("err_wrusedw", wrusedw, 0);
        chk("err_rdempty", rdempty, 1);
        repeat (255) pkt(4, 0, 0);
        chk("fill_wrusedw", wrusedw, 1020);
        for (int i = 0; i < 10; i++) begin
            cyc(1, i == 0, i == 9, 0, 0);
            if (i == 3) chk("ovf_wrfull", wrfull, 1);
            if (i == 4) begin
                chk("ovf_rewind", wrusedw, 1020);
                chk("ovf_drop", wr_drop, 1);
                chk("ovf_drop_cnt", drop_cnt, 2);
            end
        end
        chk("ovf_after_eop", wrusedw, 1020);
        rd(4);
        pkt(2, 0, 0);
        chk("ovf_next_rdusedw", rdusedw, 1018);
        chk("ovf_next_pkt_cnt", pkt_cnt, 255);
        rd(1018);
        chk("ovf_drained", rdempty, 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("abort_drop_cnt", drop_cnt, 3);
        chk("abort_pkt_cnt", pkt_cnt, 1);
        chk("abort_rdusedw", rdusedw, 2);
        rd(2);
        pkt(2, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 1, 0, 1);
        chk("simul_pkt_cnt", pkt_cnt, 1);
        rd(2);
        repeat (3000) cyc(1, 1, 1, 0, 1);
        chk("wrap_no_drops", drop_cnt, 3);
        rd(2);
        chk("wrap_drained", rdempty, 1);
        repeat (3000)
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        reset_ = 0;
        @(posedge clk);
        #2;
        chk("midrst_wrusedw", wrusedw, 0);
        chk("midrst_pkt_cnt", pkt_cnt, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        chk("midrst_rdempty", rdempty, 1);
        reset_ = 1;
        cyc(1, 0, 1, 0, 0);
        pkt(2, 0, 0);
        chk("post_rst_rdusedw", rdusedw, 2);
        rd(2);
        chk("post_rst_pkt_cnt", pkt_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rx_pkt_buf_1024x256.md
Name: rx_pkt_buf_1024x256

Overview:
- Single-clock, store-and-forward receive packet buffer for the OmniXtend core's Ethernet ingress path.
- It is the receive-side counterpart of the transmit packet FIFO. It accepts 256-bit beats from the MAC RX interface and exposes only fully committed, error-free packets to the TileLink/OX decode logic.
- Errored, aborted or overflowing packets are rewound and discarded, so the reader never sees partial frames.

Parameters:
- WIDTH, 256, data beat width in bits.
- DEPTH, 1024, buffer depth in beats; must be a power of two.
- PTR, 10, log2(DEPTH). Internal pointers are PTR+1 bits wide.

Ports:
- clk  in  1  single clock for both write and read sides.
- reset_  in  1  asynchronous, active-low reset.
- wren  in  1  write strobe; one beat is presented per asserted cycle.
- wr_sop  in  1  start of packet, qualified by wren.
- wr_eop  in  1  end of packet, qualified by wren; a one-beat packet has sop and eop together.
- wr_err  in  1  packet bad (FCS or MAC error), sampled only on the wren && wr_eop beat.
- datain  in  WIDTH  write data.
- wrfull  out  1  high when used beats == DEPTH.
- wrusedw  out  PTR+1  beats occupied, including uncommitted beats.
- wr_drop  out  1  one-cycle pulse when a packet is discarded.
- drop_cnt  out  16  count of discarded packets; saturates at 16'hFFFF.
- rden  in  1  read strobe.
- dataout  out  WIDTH  read data, registered.
- rd_eop  out  1  end-of-packet flag, aligned with dataout.
- rdvalid  out  1  high the cycle after an accepted read.
- rdempty  out  1  high when no committed beats remain (rd_ptr == commit_ptr).
- rdusedw  out  PTR+1  committed beats not yet read.
- pkt_cnt  out  PTR+1  committed packets not yet fully read.

Behaviour:
- Reset: all pointers, pkt_cnt, drop_cnt, dataout, rd_eop, rdvalid and wr_drop are 0. rdempty=1, wrfull=0. The write FSM goes to IDLE. The memory is not cleared.
- Storage: memory is WIDTH+1 bits wide, with the eop flag in the MSB. Three pointers:
  - wr_ptr advances on every accepted write.
  - commit_ptr marks the end of the last good packet.
  - rd_ptr advances on every accepted read.
- wrusedw = wr_ptr - rd_ptr. rdusedw = commit_ptr - rd_ptr. Both use modulo 2^(PTR+1) arithmetic and wrap naturally.
- Write FSM states: IDLE, ACCUM, DISCARD.
- IDLE:
  - wren without wr_sop: beat ignored, no drop counted.
  - wren && wr_sop: store the beat. Go to ACCUM, or commit immediately if wr_eop is also high.
- ACCUM:
  - wren: store the beat.
  - wr_eop && !wr_err: commit_ptr <= wr_ptr+1, pkt_cnt++, go to IDLE.
  - wr_eop && wr_err: wr_ptr <= commit_ptr, drop, go to IDLE.
- Overflow: wren while wrfull (any state except DISCARD) rewinds wr_ptr <= commit_ptr, drops the packet and goes to DISCARD. This also covers a single-beat packet.
- DISCARD: writes are ignored until wren && wr_eop, then go to IDLE.
  - If that beat also carries wr_sop and there is room, it is treated as a new packet started from IDLE.
- Abort: wr_sop arriving in ACCUM rewinds to commit_ptr, drops the old packet, and the sop beat starts a new packet at commit_ptr (stays in ACCUM).
- Drop accounting: each drop pulses wr_drop for one cycle and increments drop_cnt (saturating).
- Read side:
  - rden && !rdempty: dataout/rd_eop <= mem[rd_ptr], rdvalid=1 on the next cycle, rd_ptr++.
  - If the popped beat has eop, pkt_cnt-- in the same cycle.
  - rden while rdempty is ignored: dataout holds, rdvalid=0.
- Simultaneous commit and last-beat read: pkt_cnt stays unchanged. rdempty and rdusedw use the pre-update pointers.
- Rewinds never move behind rd_ptr; this holds by construction because commit_ptr >= rd_ptr.
- Reset mid-packet: partial data is lost and the FSM returns to IDLE.

Test Plan:
- Reset, then write a 4-beat good packet (sop at beat 0, eop at beat 3, err=0) -> rdempty 1->0 the cycle after eop; pkt_cnt=1, rdusedw=4. Four reads give rdvalid on 4 cycles with data matching and rd_eop only on beat 4; afterwards pkt_cnt=0, rdempty=1.
- Write 3 beats with wr_err=1 on eop -> wr_drop pulses once, drop_cnt=1, wrusedw returns to 0, rdempty stays 1.
- Fill 1020 committed beats, then start a 10-beat packet -> wrfull at beat 4; beat 5 triggers a rewind (wrusedw=1020) and wr_drop. Remaining beats are ignored up to eop, and the next good 2-beat packet is accepted after reads free space.
- Send sop at beats 0 and 2 of an unterminated packet, followed by eop at beat 3 -> one drop; committed packet = beats 2..3 only, pkt_cnt=1, rdusedw=2.
- Pointer wrap: stream 3000 single-beat good packets while reading continuously -> no data mismatch, rdusedw never exceeds 1024, no drops.
- Assert rden on an empty buffer -> rdvalid=0, dataout unchanged. Commit the eop of packet B in the same cycle the last beat of packet A is read -> pkt_cnt holds at 1.
